// File: rtl/vector_cmd_parser.sv
// Decodes 5-byte UART jump/draw frames into 12-bit X/Y commands, buffers them in a
// FIFO and issues them as single-cycle draw/jump pulses when the line controller is ready.
module vector_cmd_parser #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_byte,
  input  logic                     ready,
  output logic [11:0]              x,
  output logic [11:0]              y,
  output logic                     draw,
  output logic                     jump,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_XH, S_XL, S_YH, S_YL} state_t;

  state_t        state, state_nxt;
  logic          op_r;
  logic [5:0]    xh_r, xl_r, yh_r;
  logic [TW-1:0] tmo_cnt;
  logic          err, push_req, push_ok, pop, is_hdr, tmo_hit;
  logic [24:0]   mem [DEPTH];
  logic [24:0]   head;
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign is_hdr  = rx_byte[7];
  assign tmo_hit = (state != S_IDLE) && !rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // A header always restarts a frame; a header arriving mid-frame also flags the loss.
  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    push_req  = 1'b0;
    if (rx_valid) begin
      if (is_hdr) begin
        err       = (state != S_IDLE);
        state_nxt = S_XH;
      end else begin
        case (state)
          S_IDLE: err = 1'b1;
          S_XH:   state_nxt = S_XL;
          S_XL:   state_nxt = S_YH;
          S_YH:   state_nxt = S_YL;
          S_YL: begin
            push_req  = 1'b1;
            state_nxt = S_IDLE;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end else if (tmo_hit) begin
      err       = 1'b1;
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE || rx_valid || tmo_hit) tmo_cnt <= '0;
    else                                                 tmo_cnt <= tmo_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r <= 1'b0;
      xh_r <= '0;
      xl_r <= '0;
      yh_r <= '0;
    end else if (rx_valid) begin
      if (is_hdr) op_r <= rx_byte[0];
      else begin
        case (state)
          S_XH:    xh_r <= rx_byte[5:0];
          S_XL:    xl_r <= rx_byte[5:0];
          S_YH:    yh_r <= rx_byte[5:0];
          default: ;
        endcase
      end
    end
  end

  // A full FIFO drops the frame even if a pop happens in the same cycle.
  assign push_ok = push_req && (fifo_count != CW'(DEPTH));
  assign pop     = ready && (fifo_count != '0) && !(draw || jump);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= {op_r, xh_r, xl_r, yh_r, rx_byte[5:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      x          <= '0;
      y          <= '0;
      draw       <= 1'b0;
      jump       <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overflow   <= push_req && !push_ok;
      frame_err  <= err;
      draw       <= 1'b0;
      jump       <= 1'b0;
      fifo_count <= fifo_count + CW'(push_ok) - CW'(pop);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        x      <= head[23:12];
        y      <= head[11:0];
        draw   <= head[24];
        jump   <= ~head[24];
      end
    end
  end

endmodule

// File: tb/tb_vector_cmd_parser.sv
// Randomized and directed bench for vector_cmd_parser; expected commands come from a
// byte-queue frame model and are compared against the pulses the DUT issues.
module tb_vector_cmd_parser;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 40;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          ready = 1'b0;
  logic [11:0]   x, y;
  logic          draw, jump, overflow, frame_err;
  logic [CW-1:0] fifo_count;

  int          total = 0;
  int          bad = 0;
  int          err_cnt = 0;
  int          ovf_cnt = 0;
  int          exp_err = 0;
  logic [24:0] got_q[$];
  logic [24:0] exp_q[$];
  logic [7:0]  part_q[$];
  bit          rand_ready = 0;
  bit          skip_chk = 1;
  logic        prev_pulse = 1'b0;
  logic [11:0] prev_x = '0, prev_y = '0;

  vector_cmd_parser #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte), .ready(ready),
    .x(x), .y(y), .draw(draw), .jump(jump), .fifo_count(fifo_count),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Protocol monitor: collects issued commands and pulse counts, checks pulse rules.
  always @(negedge clk) begin
    if (reset) begin
      skip_chk = 1;
    end else if (skip_chk) begin
      skip_chk   = 0;
      prev_x     = x;
      prev_y     = y;
      prev_pulse = draw | jump;
    end else begin
      total++;
      if (draw && jump) begin
        bad++;
        $display("[TB] FAIL both_pulses: draw=%0b jump=%0b, required not both", draw, jump);
      end
      total++;
      if ((draw | jump) && prev_pulse) begin
        bad++;
        $display("[TB] FAIL back_to_back: pulse in consecutive cycles, required idle gap");
      end
      if (!(draw | jump)) begin
        total++;
        if ({x, y} !== {prev_x, prev_y}) begin
          bad++;
          $display("[TB] FAIL xy_hold: x=%h y=%h, required x=%h y=%h", x, y, prev_x, prev_y);
        end
      end
      if (draw | jump) got_q.push_back({draw, x, y});
      if (frame_err) err_cnt++;
      if (overflow) ovf_cnt++;
      prev_x     = x;
      prev_y     = y;
      prev_pulse = draw | jump;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    if (rand_ready) ready = 1'($urandom_range(0, 1));
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (rand_ready) ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  // Reference model: a frame is a header followed by four data bytes, nothing more.
  task automatic model_byte(input logic [7:0] b);
    if (b[7]) begin
      if (part_q.size() > 0) exp_err++;
      part_q.delete();
      part_q.push_back(b);
    end else if (part_q.size() == 0) begin
      exp_err++;
    end else begin
      part_q.push_back(b);
      if (part_q.size() == 5) begin
        exp_q.push_back({part_q[0][0], part_q[1][5:0], part_q[2][5:0],
                         part_q[3][5:0], part_q[4][5:0]});
        part_q.delete();
      end
    end
  endtask

  task automatic send_model(input logic [7:0] b);
    model_byte(b);
    send_byte(b);
  endtask

  task automatic send_frame(input logic op, input logic [11:0] fx, input logic [11:0] fy);
    send_model({7'b1000000, op});
    send_model({2'b00, fx[11:6]});
    send_model({2'b00, fx[5:0]});
    send_model({2'b00, fy[11:6]});
    send_model({2'b00, fy[5:0]});
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    part_q.delete();
    err_cnt = 0;
    ovf_cnt = 0;
    exp_err = 0;
  endtask

  task automatic compare_cmds(input string name);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("[TB] FAIL %s_count: got %0d commands, required %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("[TB] FAIL %s_cmd%0d: got %h, required %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic check_zero_outputs(input string name);
    total++;
    if ({fifo_count, x, y, draw, jump, overflow, frame_err} !== '0) begin
      bad++;
      $display("[TB] FAIL %s: count=%0d x=%h y=%h d=%b j=%b ov=%b fe=%b, required all 0",
               name, fifo_count, x, y, draw, jump, overflow, frame_err);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h81;
    idle(3);
    rx_valid = 1'b0;
    reset    = 1'b0;
    check_zero_outputs("reset_state");
    clear_obs();
    idle(3);
    total++;
    if (err_cnt != 0 || fifo_count !== '0) begin
      bad++;
      $display("[TB] FAIL reset_ignore: errs=%0d count=%0d, required 0 0", err_cnt, fifo_count);
    end
  endtask

  task automatic test_single_draw();
    clear_obs();
    ready = 1'b1;
    send_byte(8'h81); send_byte(8'h3F); send_byte(8'h3F); send_byte(8'h00); send_byte(8'h01);
    total++;
    if (fifo_count !== CW'(1) || draw !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_push: count=%0d draw=%b, required 1 0", fifo_count, draw);
    end
    @(negedge clk);
    total++;
    if ({draw, jump, x, y, fifo_count} !== {1'b1, 1'b0, 12'hFFF, 12'h001, CW'(0)}) begin
      bad++;
      $display("[TB] FAIL single_issue: d=%b j=%b x=%h y=%h count=%0d, required 1 0 fff 001 0",
               draw, jump, x, y, fifo_count);
    end
    @(negedge clk);
    total++;
    if (draw !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_pulse_len: draw=%b, required 0", draw);
    end
    idle(2);
  endtask

  task automatic test_fifo_order();
    clear_obs();
    ready = 1'b0;
    send_frame(1'b0, 12'd1, 12'd2);
    send_frame(1'b1, 12'd3, 12'd4);
    send_frame(1'b1, 12'd64, 12'd64);
    idle(2);
    total++;
    if (fifo_count !== CW'(3)) begin
      bad++;
      $display("[TB] FAIL order_count: got %0d, required 3", fifo_count);
    end
    exp_q.delete();
    exp_q.push_back({1'b0, 12'd1, 12'd2});
    exp_q.push_back({1'b1, 12'd3, 12'd4});
    exp_q.push_back({1'b1, 12'd64, 12'd64});
    ready = 1'b1;
    idle(10);
    compare_cmds("order");
    total++;
    if (fifo_count !== CW'(0)) begin
      bad++;
      $display("[TB] FAIL order_drain: count=%0d, required 0", fifo_count);
    end
  endtask

  task automatic test_overflow();
    logic [24:0] kept[$];
    clear_obs();
    ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(i[0], 12'(i * 3 + 1), 12'(4000 - i));
      if (i < DEPTH) kept.push_back({i[0], 12'(i * 3 + 1), 12'(4000 - i)});
    end
    idle(2);
    total++;
    if (fifo_count !== CW'(DEPTH)) begin
      bad++;
      $display("[TB] FAIL ovf_count: got %0d, required %0d", fifo_count, DEPTH);
    end
    total++;
    if (ovf_cnt != 1) begin
      bad++;
      $display("[TB] FAIL ovf_pulses: got %0d, required 1", ovf_cnt);
    end
    exp_q = kept;
    ready = 1'b1;
    idle(3 * DEPTH + 10);
    compare_cmds("ovf");
  endtask

  task automatic test_resync();
    clear_obs();
    ready = 1'b1;
    send_byte(8'h81); send_byte(8'h05);
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h07); send_byte(8'h00); send_byte(8'h09);
    idle(6);
    total++;
    if (err_cnt != 1) begin
      bad++;
      $display("[TB] FAIL resync_err: got %0d, required 1", err_cnt);
    end
    exp_q.delete();
    exp_q.push_back({1'b0, 12'd7, 12'd9});
    compare_cmds("resync");
    clear_obs();
    send_byte(8'h12);
    idle(4);
    total++;
    if (err_cnt != 1 || got_q.size() != 0 || fifo_count !== CW'(0)) begin
      bad++;
      $display("[TB] FAIL stray_byte: errs=%0d cmds=%0d count=%0d, required 1 0 0",
               err_cnt, got_q.size(), fifo_count);
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    send_byte(8'h81); send_byte(8'h01);
    idle(TIMEOUT - 3);
    total++;
    if (err_cnt != 0) begin
      bad++;
      $display("[TB] FAIL timeout_early: errs=%0d, required 0", err_cnt);
    end
    idle(10);
    total++;
    if (err_cnt != 1) begin
      bad++;
      $display("[TB] FAIL timeout_fire: errs=%0d, required 1", err_cnt);
    end
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    idle(3);
    total++;
    if (err_cnt != 4 || fifo_count !== CW'(0) || got_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL timeout_after: errs=%0d count=%0d cmds=%0d, required 4 0 0",
               err_cnt, fifo_count, got_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    clear_obs();
    ready = 1'b0;
    send_frame(1'b1, 12'd10, 12'd20);
    send_frame(1'b0, 12'd30, 12'd40);
    send_byte(8'h80); send_byte(8'h01);
    idle(1);
    total++;
    if (fifo_count !== CW'(2)) begin
      bad++;
      $display("[TB] FAIL midframe_count: got %0d, required 2", fifo_count);
    end
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h05;
    idle(2);
    rx_valid = 1'b0;
    reset    = 1'b0;
    check_zero_outputs("midframe_reset");
    clear_obs();
    ready = 1'b1;
    send_byte(8'h81); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    idle(6);
    exp_q.push_back({1'b1, 12'd131, 12'd261});
    compare_cmds("post_reset");
    total++;
    if (err_cnt != 0) begin
      bad++;
      $display("[TB] FAIL post_reset_err: errs=%0d, required 0", err_cnt);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      clear_obs();
      rand_ready = 1;
      for (int k = 0; k < 12; k++) begin
        int kind;
        kind = $urandom_range(0, 4);
        if (kind <= 2) begin
          send_model({1'b1, 6'($urandom), 1'($urandom)});
          for (int j = 0; j < 4; j++) begin
            send_model({1'b0, 7'($urandom)});
            idle($urandom_range(0, 3));
          end
        end else if (kind == 3) begin
          int n;
          n = $urandom_range(0, 3);
          send_model({1'b1, 6'($urandom), 1'($urandom)});
          for (int j = 0; j < n; j++) send_model({1'b0, 7'($urandom)});
        end else begin
          send_model({1'b0, 7'($urandom)});
        end
        idle($urandom_range(0, 3));
      end
      if (part_q.size() > 0) begin
        exp_err++;
        part_q.delete();
      end
      idle(TIMEOUT + 5);
      rand_ready = 0;
      ready = 1'b1;
      idle(40);
      compare_cmds("random");
      total++;
      if (err_cnt != exp_err || ovf_cnt != 0 || fifo_count !== CW'(0)) begin
        bad++;
        $display("[TB] FAIL random_status: errs=%0d ovf=%0d count=%0d, required %0d 0 0",
                 err_cnt, ovf_cnt, fifo_count, exp_err);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_draw();
    test_fifo_order();
    test_overflow();
    test_resync();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_cmd_parser.md
Name: vector_cmd_parser

Overview:
Upstream stage of the vector line-draw controller. Consumes the byte stream from the UART receiver (valid strobe plus byte), decodes 5-byte jump/draw frames into 12-bit X/Y commands, and buffers them in a FIFO. Commands are issued as single-cycle draw/jump pulses with stable x/y whenever the line controller signals ready. Replaces the hard-coded pattern generator in the board top.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >=2); entry = {op, x[11:0], y[11:0]}
TIMEOUT, 100000, idle clk cycles after which a partial frame is discarded

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
rx_valid  in  1  one-cycle strobe, rx_byte valid (UART o_Rx_DV)
rx_byte  in  8  received byte (UART o_Rx_Byte)
ready  in  1  line controller can accept a command
x  out  12  target X, held between issues
y  out  12  target Y, held between issues
draw  out  1  one-cycle pulse: draw line to (x,y)
jump  out  1  one-cycle pulse: move beam blanked to (x,y)
fifo_count  out  $clog2(DEPTH)+1  entries currently buffered
overflow  out  1  one-cycle pulse: complete frame dropped, FIFO full
frame_err  out  1  one-cycle pulse: malformed/timed-out frame discarded

Behaviour:
- Frame: header byte (bit7=1; bit0 op: 0=jump, 1=draw; bits6:1 ignored), then 4 data bytes (bit7=0; payload bits5:0; bit6 ignored): XH, XL, YH, YL. x={XH[5:0],XL[5:0]}, y={YH[5:0],YL[5:0]}.
- Parser FSM: IDLE, XH, XL, YH, YL. Advances only on rx_valid.
  - IDLE: header -> latch op, go XH; data byte -> discard, frame_err pulse.
  - XH/XL/YH: data byte -> store, advance. YL: data byte -> frame complete, push, go IDLE.
  - Header in any non-IDLE state -> frame_err pulse, latch new op, go XH (resync).
- Timeout: idle counter cleared on every rx_valid; in non-IDLE state, counter reaching TIMEOUT -> go IDLE, frame_err pulse. Counter held at 0 in IDLE.
- Push: completing byte accepted cycle N; entry written at end of N; fifo_count incremented, visible cycle N+1. If fifo_count==DEPTH (registered value) in cycle N: frame dropped, overflow pulse in N+1, FIFO unchanged. Simultaneous pop does not rescue a push when full.
- Issue: in cycle M, if ready=1, fifo_count!=0, and draw|jump was 0 in M: pop head; in M+1 x,y = entry coords, draw=op or jump=~op for exactly one cycle. Minimum one idle cycle between pulses (no back-to-back pulses). x/y hold until next issue.
- Simultaneous push and pop: both performed, fifo_count unchanged.
- draw and jump never both high. Pointers wrap modulo DEPTH.
- Reset (any time, incl. mid-frame or mid-pulse): FSM IDLE, FIFO emptied, fifo_count=0, x=0, y=0, draw=0, jump=0, overflow=0, frame_err=0, timeout counter=0. Bytes strobed during reset ignored.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then bytes 0x81,0x3F,0x3F,0x00,0x01 with ready=1 -> fifo_count 1 for one cycle, then draw pulse 1 cycle with x=0xFFF, y=0x001; fifo_count back to 0.
- ready=0; send 3 frames (0x80,0,1,0,2 / 0x81,0,3,0,4 / 0x81,0x01,0,0x01,0) -> fifo_count=3; raise ready -> jump(1,2), draw(3,4), draw(64,64) in order, each 1-cycle pulse separated by >=1 idle cycle.
- ready=0; send DEPTH+1 frames -> fifo_count=DEPTH, one overflow pulse; after draining, DEPTH commands out, last frame absent.
- Send 0x81,0x05, then 0x80,0,7,0,9 -> one frame_err pulse, single jump with x=7, y=9; stray 0x12 in IDLE -> frame_err, no command.
- Send 0x81,0x01 then idle TIMEOUT cycles -> frame_err pulse; following 0x00,0x02,0x00 bytes -> 3 frame_err pulses, FIFO empty.
- Assert reset during a frame with fifo_count=2 -> all outputs 0, fifo_count 0; subsequent valid frame decoded correctly.
